// File: rtl/jacaranda_defs.sv
// Shared jacaranda-8 instruction field layout.
// Both the decoder and the loader-side encoder take their field positions from here.
package jacaranda_defs;

    localparam int INSTR_W = 8;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 2;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef logic [INSTR_W-1:0] instr_t;

    function automatic instr_t pack_instr(
        input logic [3:0] opcode,
        input logic [1:0] rd,
        input logic [1:0] rs,
        input logic [3:0] imm,
        input logic       use_imm
    );
        instr_t w;
        w = '0;
        w[OPC_MSB:OPC_LSB] = opcode;
        if (use_imm) begin
            w[IMM_MSB:IMM_LSB] = imm;
        end else begin
            w[RD_MSB:RD_LSB] = rd;
            w[RS_MSB:RS_LSB] = rs;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and async active-low reset.
// Full/empty come from the occupancy register, so they never depend on this cycle's push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = store[rptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) store[wptr] <= din;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into jacaranda-8 words and streams them
// into instruction memory through a small FIFO and an address counter.
module instr_encoder_loader
    import jacaranda_defs::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [1:0]        in_rd,
    input  logic [1:0]        in_rs,
    input  logic [3:0]        in_imm,
    input  logic              in_use_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              wrapped,
    output logic              busy
);

    instr_t packed_word;
    logic   full;
    logic   empty;
    logic   done;

    assign packed_word = pack_instr(in_opcode, in_rd, in_rs,
                                    in_imm, in_use_imm);

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (in_valid),
        .pop     (mem_ready),
        .flush   (clear),
        .din     (packed_word),
        .dout    (mem_wdata),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready = ~full;
    assign mem_we   = ~empty;
    assign busy     = ~empty;
    assign done     = mem_we & mem_ready;

    // base_load outranks a completing write; that write still used the old address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr <= '0;
            wr_count <= '0;
            wrapped  <= 1'b0;
        end else if (base_load) begin
            mem_addr <= base_addr;
            wr_count <= '0;
            wrapped  <= 1'b0;
        end else if (done) begin
            mem_addr <= mem_addr + 1'b1;
            if (wr_count != '1) wr_count <= wr_count + 1'b1;
            if (mem_addr == '1) wrapped <= 1'b1;
        end
    end

endmodule
